// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state codes, datapath
// select codes, instruction class codes and the bundled control word.
package mc_pkg;

    localparam int STATE_W = 4;

    // Main controller states; codes 11..15 are spare and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Instruction class (Op field)
    localparam logic [1:0] OP_DP       = 2'b00;
    localparam logic [1:0] OP_MEM      = 2'b01;
    localparam logic [1:0] OP_BRANCH   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL  = 2'b11;

    // Control word driven into the datapath
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
    } ctrl_t;

    // All-inactive control word; the safe value for any state not listed.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/mc_fsm_outdec.sv
// Combinational state -> control decode for the multicycle main controller.
// Pure Moore decode, except the memory-facing strobes which are gated by MemRdy
// so that a stalled access never loads the IR, bumps the PC or writes memory.
module mc_fsm_outdec
    import mc_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_rdy_i,
    output ctrl_t  ctrl_o
);

    // Decode the current state into datapath selects and enables.
    always_comb begin
        ctrl_o = ctrl_idle();
        case (state_i)
            S_FETCH: begin
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.alu_op     = 1'b0;
                ctrl_o.ir_write   = mem_rdy_i;
                ctrl_o.next_pc    = mem_rdy_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.alu_op     = 1'b0;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a  = SRCA_RD1;
                ctrl_o.alu_src_b  = SRCB_EXTIMM;
                ctrl_o.alu_op     = 1'b0;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_w      = mem_rdy_i;
            end
            S_EXECUTER: begin
                ctrl_o.alu_src_a  = SRCA_RD1;
                ctrl_o.alu_src_b  = SRCB_RD2;
                ctrl_o.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl_o.alu_src_a  = SRCA_RD1;
                ctrl_o.alu_src_b  = SRCB_EXTIMM;
                ctrl_o.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_ALUOUT;
                ctrl_o.alu_src_b  = SRCB_EXTIMM;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.alu_op     = 1'b0;
                ctrl_o.branch     = 1'b1;
            end
            S_UNKNOWN: begin
                ctrl_o = ctrl_idle();
            end
            default: begin
                ctrl_o = ctrl_idle();
            end
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Moore main controller for the multicycle datapath. Holds the state register,
// the next-state logic and the sticky Illegal flag; the output decode lives in
// mc_fsm_outdec.
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemRdy,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal
);

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;
    ctrl_t  ctrl_s;
    logic   funct_i_s;
    logic   funct_l_s;
    logic   unused_funct_s;

    assign funct_i_s      = Funct[5];
    assign funct_l_s      = Funct[0];
    // Middle Funct bits belong to the ALU decoder, not to sequencing.
    assign unused_funct_s = ^Funct[4:1];

    // Next-state sequencing; memory states wait for MemRdy, spare codes recover to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemRdy) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_DP: begin
                        if (funct_i_s) begin
                            state_d = S_EXECUTEI;
                        end else begin
                            state_d = S_EXECUTER;
                        end
                    end
                    OP_MEM:     state_d = S_MEMADR;
                    OP_BRANCH:  state_d = S_BRANCH;
                    OP_ILLEGAL: state_d = S_UNKNOWN;
                    default:    state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                if (funct_l_s) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (MemRdy) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (MemRdy) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB:    state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Illegal becomes set on the same edge that enters UNKNOWN and stays set until reset.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_UNKNOWN);
    end

    // State and sticky-flag registers; reset drops any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mc_fsm_outdec u_outdec (
        .state_i   (state_q),
        .mem_rdy_i (MemRdy),
        .ctrl_o    (ctrl_s)
    );

    assign IRWrite   = ctrl_s.ir_write;
    assign AdrSrc    = ctrl_s.adr_src;
    assign ALUSrcA   = ctrl_s.alu_src_a;
    assign ALUSrcB   = ctrl_s.alu_src_b;
    assign ResultSrc = ctrl_s.result_src;
    assign ALUOp     = ctrl_s.alu_op;
    assign NextPC    = ctrl_s.next_pc;
    assign RegW      = ctrl_s.reg_w;
    assign MemW      = ctrl_s.mem_w;
    assign Branch    = ctrl_s.branch;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: a per-cycle vector table of inputs with
// hand-derived state and control word, plus a hand-written reset sequence.
module tb_mc_main_fsm;

    // State codes as the bench expects them
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXR    = 4'd6;
    localparam logic [3:0] ST_EXI    = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BR     = 4'd9;
    localparam logic [3:0] ST_UNK    = 4'd10;

    // Control word {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,Illegal}
    localparam logic [13:0] O_FETCH_R = 14'b1_0_01_10_10_0_1_0_0_0_0;
    localparam logic [13:0] O_FETCH_W = 14'b0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [13:0] O_DECODE  = 14'b0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [13:0] O_MEMADR  = 14'b0_0_00_01_00_0_0_0_0_0_0;
    localparam logic [13:0] O_MEMRD   = 14'b0_1_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] O_MEMWB   = 14'b0_0_00_00_01_0_0_1_0_0_0;
    localparam logic [13:0] O_MEMWR_R = 14'b0_1_00_00_00_0_0_0_1_0_0;
    localparam logic [13:0] O_MEMWR_W = 14'b0_1_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] O_EXR     = 14'b0_0_00_00_00_1_0_0_0_0_0;
    localparam logic [13:0] O_EXI     = 14'b0_0_00_01_00_1_0_0_0_0_0;
    localparam logic [13:0] O_ALUWB   = 14'b0_0_00_00_00_0_0_1_0_0_0;
    localparam logic [13:0] O_BR      = 14'b0_0_10_01_10_0_0_0_0_1_0;
    localparam logic [13:0] O_UNK     = 14'b0_0_00_00_00_0_0_0_0_0_0;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_rdy;
    logic       ir_write, adr_src, alu_op, next_pc, reg_w, mem_w, branch, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [13:0] got_word;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        mrdy;
        logic [3:0]  st;
        logic [13:0] out;
    } vec_t;

    vec_t vecs[$];

    mc_main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (op),
        .Funct     (funct),
        .MemRdy    (mem_rdy),
        .IRWrite   (ir_write),
        .AdrSrc    (adr_src),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .ResultSrc (result_src),
        .ALUOp     (alu_op),
        .NextPC    (next_pc),
        .RegW      (reg_w),
        .MemW      (mem_w),
        .Branch    (branch),
        .Illegal   (illegal)
    );

    assign got_word = {ir_write, adr_src, alu_src_a, alu_src_b, result_src,
                       alu_op, next_pc, reg_w, mem_w, branch, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] o, input logic [5:0] f, input logic m,
                       input logic [3:0] st, input logic [13:0] w, input logic ill);
        vec_t v;
        v.op    = o;
        v.funct = f;
        v.mrdy  = m;
        v.st    = st;
        v.out   = w | {13'b0, ill};
        vecs.push_back(v);
    endtask

    initial begin
        // Data-processing, register operand: 4 cycles
        add(2'b00, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b00, 6'b000000, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b00, 6'b000000, 1'b1, ST_EXR,    O_EXR,     1'b0);
        add(2'b00, 6'b000000, 1'b1, ST_ALUWB,  O_ALUWB,   1'b0);
        // Data-processing, immediate operand
        add(2'b00, 6'b100000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b00, 6'b100000, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b00, 6'b100000, 1'b1, ST_EXI,    O_EXI,     1'b0);
        add(2'b00, 6'b100000, 1'b1, ST_ALUWB,  O_ALUWB,   1'b0);
        // LDR with memory stalled 2 cycles in MEMREAD
        add(2'b01, 6'b000001, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b01, 6'b000001, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b01, 6'b000001, 1'b1, ST_MEMADR, O_MEMADR,  1'b0);
        add(2'b01, 6'b000001, 1'b0, ST_MEMRD,  O_MEMRD,   1'b0);
        add(2'b01, 6'b000001, 1'b0, ST_MEMRD,  O_MEMRD,   1'b0);
        add(2'b01, 6'b000001, 1'b1, ST_MEMRD,  O_MEMRD,   1'b0);
        add(2'b01, 6'b000001, 1'b1, ST_MEMWB,  O_MEMWB,   1'b0);
        // STR with a fetch stall and a 2-cycle MEMWRITE stall
        add(2'b01, 6'b000000, 1'b0, ST_FETCH,  O_FETCH_W, 1'b0);
        add(2'b01, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b01, 6'b000000, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b01, 6'b000000, 1'b1, ST_MEMADR, O_MEMADR,  1'b0);
        add(2'b01, 6'b000000, 1'b0, ST_MEMWR,  O_MEMWR_W, 1'b0);
        add(2'b01, 6'b000000, 1'b0, ST_MEMWR,  O_MEMWR_W, 1'b0);
        add(2'b01, 6'b000000, 1'b1, ST_MEMWR,  O_MEMWR_R, 1'b0);
        // Branch: 3 cycles
        add(2'b10, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b10, 6'b000000, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b10, 6'b000000, 1'b1, ST_BR,     O_BR,      1'b0);
        // LDR without stalls: 5 cycles
        add(2'b01, 6'b100001, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b01, 6'b100001, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b01, 6'b100001, 1'b1, ST_MEMADR, O_MEMADR,  1'b0);
        add(2'b01, 6'b100001, 1'b1, ST_MEMRD,  O_MEMRD,   1'b0);
        add(2'b01, 6'b100001, 1'b1, ST_MEMWB,  O_MEMWB,   1'b0);
        // Illegal: Illegal rises on the edge into UNKNOWN and then sticks
        add(2'b11, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b0);
        add(2'b11, 6'b000000, 1'b1, ST_DECODE, O_DECODE,  1'b0);
        add(2'b11, 6'b000000, 1'b1, ST_UNK,    O_UNK,     1'b1);
        add(2'b00, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b1);
        add(2'b00, 6'b000000, 1'b1, ST_DECODE, O_DECODE,  1'b1);
        add(2'b00, 6'b000000, 1'b1, ST_EXR,    O_EXR,     1'b1);
        add(2'b00, 6'b000000, 1'b1, ST_ALUWB,  O_ALUWB,   1'b1);
        add(2'b00, 6'b000000, 1'b0, ST_FETCH,  O_FETCH_W, 1'b1);
        add(2'b00, 6'b000000, 1'b0, ST_FETCH,  O_FETCH_W, 1'b1);
        add(2'b00, 6'b000000, 1'b1, ST_FETCH,  O_FETCH_R, 1'b1);

        // Reset state, asserted without any clock edge
        reset   = 1'b0;
        op      = 2'b00;
        funct   = 6'b000000;
        mem_rdy = 1'b1;
        #1;
        check("reset_state", {10'b0, dut.state_q}, {10'b0, ST_FETCH});
        check("reset_outputs", got_word, O_FETCH_R);

        @(negedge clk);
        reset = 1'b1;

        // Table: drive on the falling edge, compare before the next rising edge
        for (int i = 0; i < vecs.size(); i++) begin
            op      = vecs[i].op;
            funct   = vecs[i].funct;
            mem_rdy = vecs[i].mrdy;
            #1;
            check($sformatf("vec%0d_state", i), {10'b0, dut.state_q}, {10'b0, vecs[i].st});
            check($sformatf("vec%0d_outputs", i), got_word, vecs[i].out);
            @(negedge clk);
        end

        // Reset mid-MEMWB (table left the FSM in DECODE with Illegal set)
        op      = 2'b01;
        funct   = 6'b000001;
        mem_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_memwb", got_word, O_MEMWB | 14'b1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_state", {10'b0, dut.state_q}, {10'b0, ST_FETCH});
        check("async_reset_outputs", got_word, O_FETCH_R);
        check("async_reset_regw", {13'b0, reg_w}, 14'b0);
        check("async_reset_illegal", {13'b0, illegal}, 14'b0);

        // Held in reset across a rising edge: still FETCH, no write strobes
        @(negedge clk);
        #1;
        check("held_reset_outputs", got_word, O_FETCH_R);
        reset   = 1'b1;
        mem_rdy = 1'b0;
        #1;
        check("release_fetch_stall", got_word, O_FETCH_W);
        @(negedge clk);
        #1;
        check("fetch_stall_state", {10'b0, dut.state_q}, {10'b0, ST_FETCH});
        mem_rdy = 1'b1;
        @(negedge clk);
        #1;
        check("after_reset_decode", {10'b0, dut.state_q}, {10'b0, ST_DECODE});
        check("after_reset_outputs", got_word, O_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
